semaforo_monitor: RTL and testbench

- Passive checker on the two light buses of the traffic-light controller.
- Decodes the one-hot lights `A` and `B` every cycle and tracks each phase's duration.
- Flags illegal encodings, out-of-order transitions, short phases and cross-direction conflicts.
- Sits beside the controller in simulation and on silicon; drives nothing back into it.

---
 rtl/semaforo_if.sv | 9 +
 rtl/semaforo_monitor.sv | 85 ++++++++
 tb/tb_semaforo_monitor.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/semaforo_if.sv
// semaforo_if: light buses into the monitor and the monitor's result signals.
interface semaforo_if #(parameter int CNT_W = 9);
  logic [2:0] A, B;
  logic done_a, done_b, conflict, err_pulse;
  logic [2:0] color_a, color_b, err_a, err_b;
  logic [CNT_W-1:0] len_a, len_b;
  modport master(output A, B, input done_a, color_a, len_a, done_b, color_b, len_b, err_a, err_b, conflict, err_pulse);
  modport slave(input A, B, output done_a, color_a, len_a, done_b, color_b, len_b, err_a, err_b, conflict, err_pulse);
endinterface

// File: rtl/semaforo_monitor.sv
// semaforo_monitor: passive checker of the A/B light buses; conflict check enabled by SEMAFORO_MON_CONFLICT_EN.
module semaforo_monitor #(
  parameter int CNT_W = 9,
  parameter int MIN_RED = 4,
  parameter int MIN_YELLOW = 2,
  parameter int MIN_GREEN = 4
) (
  input logic clk,
  input logic rst,
  semaforo_if.slave mon
);
  typedef enum logic [1:0] {UNSYNC, FIRST, RUN} state_e;
  state_e st_q [2], st_d [2];
  logic [2:0] x [2], p_q [2], color_q [2], err_q [2], ev [2];
  logic [CNT_W-1:0] cnt_q [2], cnt_d [2], len_q [2];
  logic [1:0] lx, lp, chg, ins, done_q;
  logic cf_ev, conflict_q, pulse_q;
  function automatic logic legal(input logic [2:0] v);
    return v == 3'b001 || v == 3'b010 || v == 3'b100;
  endfunction
  function automatic logic [CNT_W-1:0] min_len(input logic [2:0] v);
    return v[0] ? CNT_W'(MIN_RED) : v[1] ? CNT_W'(MIN_YELLOW) : CNT_W'(MIN_GREEN);
  endfunction
  assign x[0] = mon.A;
  assign x[1] = mon.B;
  // in-order successor is a left rotation: red -> yellow -> green -> red
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      lx[c] = legal(x[c]);
      lp[c] = legal(p_q[c]);
      chg[c] = lp[c] && x[c] != p_q[c];
      ins[c] = x[c] == {p_q[c][1:0], p_q[c][2]};
      ev[c] = {lx[c] && chg[c] && ins[c] && st_q[c] == RUN && cnt_q[c] < min_len(p_q[c]),
               lx[c] && chg[c] && !ins[c],
               !lx[c] && (lp[c] || x[c] != p_q[c])};
      st_d[c] = !lx[c] ? UNSYNC : (st_q[c] == UNSYNC || (chg[c] && !ins[c])) ? FIRST : chg[c] ? RUN : st_q[c];
      cnt_d[c] = !lx[c] ? '0 : (chg[c] || st_q[c] == UNSYNC) ? CNT_W'(1) :
                 (&cnt_q[c]) ? cnt_q[c] : cnt_q[c] + CNT_W'(1);
    end
  end
`ifdef SEMAFORO_MON_CONFLICT_EN
  assign cf_ev = lx[0] && lx[1] && !x[0][0] && !x[1][0];
`else
  assign cf_ev = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        st_q[c] <= UNSYNC;
        p_q[c] <= '0;
        cnt_q[c] <= '0;
        color_q[c] <= '0;
        len_q[c] <= '0;
        err_q[c] <= '0;
      end
      done_q <= '0;
      conflict_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        st_q[c] <= st_d[c];
        p_q[c] <= x[c];
        cnt_q[c] <= cnt_d[c];
        err_q[c] <= err_q[c] | ev[c];
        if (chg[c]) begin
          color_q[c] <= p_q[c];
          len_q[c] <= cnt_q[c];
        end
      end
      done_q <= chg;
      conflict_q <= conflict_q | cf_ev;
      pulse_q <= |{ev[0], ev[1], cf_ev};
    end
  end
  assign mon.done_a = done_q[0];
  assign mon.done_b = done_q[1];
  assign mon.color_a = color_q[0];
  assign mon.color_b = color_q[1];
  assign mon.len_a = len_q[0];
  assign mon.len_b = len_q[1];
  assign mon.err_a = err_q[0];
  assign mon.err_b = err_q[1];
  assign mon.conflict = conflict_q;
  assign mon.err_pulse = pulse_q;
endmodule

// File: tb/tb_semaforo_monitor.sv
// tb_semaforo_monitor: two monitors (CNT_W 9 and 4) on shared stimulus, checked by a queued reference model.
module tb_semaforo_monitor;
`ifdef SEMAFORO_MON_CONFLICT_EN
  localparam bit CF_EN = 1'b1;
`else
  localparam bit CF_EN = 1'b0;
`endif
  typedef struct packed {
    logic [3:0] done;
    logic [3:0][2:0] color;
    logic [3:0][8:0] len;
    logic [3:0][2:0] err;
    logic [1:0] cf;
    logic [1:0] pulse;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  int pass = 0, total = 0;
  exp_t e, exp_q[$];
  logic [2:0] m_prev [4];
  int m_tr [4], m_len [4];
  int lim [2] = '{511, 15};
  int mins [3] = '{4, 2, 4};
  semaforo_if #(.CNT_W(9)) if0();
  semaforo_if #(.CNT_W(4)) if1();
  semaforo_monitor #(.CNT_W(9)) dut0 (.clk(clk), .rst(rst), .mon(if0));
  semaforo_monitor #(.CNT_W(4)) dut1 (.clk(clk), .rst(rst), .mon(if1));
  always #5 clk = ~clk;
  function automatic int col(input logic [2:0] v);
    return v == 3'b001 ? 0 : v == 3'b010 ? 1 : v == 3'b100 ? 2 : -1;
  endfunction
  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  // colour indices: red 0, yellow 1, green 2; in order means index + 1 mod 3
  task automatic model(input logic [2:0] a, input logic [2:0] b, input logic r);
    int ci, pi, u;
    logic [2:0] x, ev;
    e.done = '0;
    e.pulse = '0;
    for (int k = 0; k < 4; k++) begin
      u = k / 2;
      x = (k % 2 == 1) ? b : a;
      ci = col(x);
      pi = col(m_prev[k]);
      ev = '0;
      if (r) begin
        m_tr[k] = 0;
        m_len[k] = 0;
        m_prev[k] = '0;
        e.color[k] = '0;
        e.len[k] = '0;
        e.err[k] = '0;
      end else begin
        if (pi >= 0 && x != m_prev[k]) begin
          e.done[k] = 1'b1;
          e.color[k] = m_prev[k];
          e.len[k] = 9'(m_len[k]);
        end
        if (ci < 0) begin
          if (pi >= 0 || x != m_prev[k]) ev[0] = 1'b1;
          m_tr[k] = 0;
          m_len[k] = 0;
        end else if (m_tr[k] == 0) begin
          m_tr[k] = 1;
          m_len[k] = 1;
        end else if (x == m_prev[k]) begin
          m_len[k] = (m_len[k] >= lim[u]) ? lim[u] : m_len[k] + 1;
        end else begin
          if (ci != (pi + 1) % 3) begin
            ev[1] = 1'b1;
            m_tr[k] = 1;
          end else begin
            if (m_tr[k] == 2 && m_len[k] < mins[pi]) ev[2] = 1'b1;
            m_tr[k] = 2;
          end
          m_len[k] = 1;
        end
        m_prev[k] = x;
        e.err[k] = e.err[k] | ev;
        if (ev != 3'b000) e.pulse[u] = 1'b1;
      end
    end
    for (int v = 0; v < 2; v++) begin
      if (r) e.cf[v] = 1'b0;
      else if (CF_EN && col(a) > 0 && col(b) > 0) begin
        e.cf[v] = 1'b1;
        e.pulse[v] = 1'b1;
      end
    end
  endtask
  task automatic tick(input logic [2:0] a, input logic [2:0] b, input logic r);
    @(negedge clk);
    if0.A = a;
    if1.A = a;
    if0.B = b;
    if1.B = b;
    rst = r;
    model(a, b, r);
    exp_q.push_back(e);
  endtask
  task automatic hold(input logic [2:0] a, input logic [2:0] b, input int n);
    repeat (n) tick(a, b, 1'b0);
  endtask
  initial begin
    exp_t a, x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        a.done = {if1.done_b, if1.done_a, if0.done_b, if0.done_a};
        a.color = {if1.color_b, if1.color_a, if0.color_b, if0.color_a};
        a.len = {5'd0, if1.len_b, 5'd0, if1.len_a, if0.len_b, if0.len_a};
        a.err = {if1.err_b, if1.err_a, if0.err_b, if0.err_a};
        a.cf = {if1.conflict, if0.conflict};
        a.pulse = {if1.err_pulse, if0.err_pulse};
        for (int k = 0; k < 4; k++) begin
          check($sformatf("done%0d", k), a.done[k], x.done[k]);
          check($sformatf("color%0d", k), a.color[k], x.color[k]);
          check($sformatf("len%0d", k), a.len[k], x.len[k]);
          check($sformatf("err%0d", k), a.err[k], x.err[k]);
        end
        for (int v = 0; v < 2; v++) begin
          check($sformatf("conflict%0d", v), a.cf[v], x.cf[v]);
          check($sformatf("err_pulse%0d", v), a.pulse[v], x.pulse[v]);
        end
      end
    end
  end
  initial begin
    logic [2:0] cur [2], ill [4];
    int rem [2], r;
    ill = '{3'b000, 3'b011, 3'b110, 3'b111};
    cur = '{3'b001, 3'b001};
    rem = '{0, 0};
    rst = 1'b1;
    if0.A = 3'b001;
    if1.A = 3'b001;
    if0.B = 3'b001;
    if1.B = 3'b001;
    tick(3'b001, 3'b001, 1'b1);
    tick(3'b001, 3'b001, 1'b1);
    hold(3'b001, 3'b001, 10);
    hold(3'b010, 3'b001, 3);
    hold(3'b100, 3'b001, 6);
    hold(3'b001, 3'b001, 5);
    hold(3'b010, 3'b001, 1);
    hold(3'b100, 3'b001, 4);
    hold(3'b001, 3'b001, 4);
    hold(3'b100, 3'b001, 4);
    hold(3'b011, 3'b001, 2);
    hold(3'b001, 3'b001, 4);
    hold(3'b100, 3'b010, 1);
    hold(3'b001, 3'b001, 20);
    hold(3'b010, 3'b001, 3);
    tick(3'b010, 3'b001, 1'b1);
    hold(3'b010, 3'b001, 2);
    hold(3'b001, 3'b001, 520);
    hold(3'b010, 3'b010, 3);
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (rem[c] == 0) begin
          r = $urandom_range(0, 19);
          cur[c] = r < 14 ? {cur[c][1:0], cur[c][2]} :
                   r < 17 ? 3'b001 << $urandom_range(0, 2) : ill[$urandom_range(0, 3)];
          rem[c] = $urandom_range(0, 9) == 0 ? $urandom_range(14, 24) : $urandom_range(1, 6);
        end
        rem[c]--;
      end
      tick(cur[0], cur[1], $urandom_range(0, 299) == 0);
    end
    @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
